// File: rtl/sigma_pkg.sv
// rtl/sigma_pkg.sv - shared state/bank types and default tile geometry for the SIGMA bitmap compressor
package sigma_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    typedef logic bank_sel_t;

    localparam int DEF_ROW_SIZE       = 4;
    localparam int DEF_COL_SIZE       = 8;
    localparam int DEF_LOG2_ROW_SIZE  = 2;
    localparam int DEF_LOG2_COL_SIZE  = 3;
    localparam int DEF_BUFF_SIZE      = 32;
    localparam int DEF_LOG2_BUFF_SIZE = 5;
    localparam int DEF_DATA_TYPE      = 32;

endpackage

// File: rtl/bitmap_bank.sv
// rtl/bitmap_bank.sv - one tile of bitmap + packed non-zero buffer with nnz/overflow tracking and clear
module bitmap_bank
    import sigma_pkg::*;
#(
    parameter int ROW_SIZE       = DEF_ROW_SIZE,
    parameter int COL_SIZE       = DEF_COL_SIZE,
    parameter int LOG2_ROW_SIZE  = DEF_LOG2_ROW_SIZE,
    parameter int LOG2_COL_SIZE  = DEF_LOG2_COL_SIZE,
    parameter int BUFF_SIZE      = DEF_BUFF_SIZE,
    parameter int LOG2_BUFF_SIZE = DEF_LOG2_BUFF_SIZE,
    parameter int DATA_TYPE      = DEF_DATA_TYPE
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic                                 clr,
    input  logic [LOG2_ROW_SIZE-1:0]             row,
    input  logic [LOG2_COL_SIZE-1:0]             col,
    input  logic [DATA_TYPE-1:0]                 data,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0]    bit_map,
    output logic [BUFF_SIZE-1:0][DATA_TYPE-1:0]  ele,
    output logic [LOG2_BUFF_SIZE:0]              nnz,
    output logic                                 ovf
);

    localparam logic [LOG2_BUFF_SIZE:0] NNZ_MAX = (LOG2_BUFF_SIZE + 1)'(BUFF_SIZE);

    logic nonzero;
    assign nonzero = (data != '0);

    // record occupancy, pack non-zeros in scan order, drop and flag any beyond the buffer depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_map <= '0;
            ele     <= '0;
            nnz     <= '0;
            ovf     <= 1'b0;
        end else if (clr) begin
            bit_map <= '0;
            ele     <= '0;
            nnz     <= '0;
            ovf     <= 1'b0;
        end else if (wr_en) begin
            bit_map[row][col] <= nonzero;
            if (nonzero) begin
                if (nnz < NNZ_MAX) begin
                    ele[nnz[LOG2_BUFF_SIZE-1:0]] <= data;
                    nnz                          <= nnz + 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bitmap_compressor.sv
// rtl/bitmap_compressor.sv - dense tile stream to SIGMA bitmap format; define BITMAP_COMP_PINGPONG_EN for two-bank ping-pong
module bitmap_compressor
    import sigma_pkg::*;
#(
    parameter int ROW_SIZE       = DEF_ROW_SIZE,
    parameter int COL_SIZE       = DEF_COL_SIZE,
    parameter int LOG2_ROW_SIZE  = DEF_LOG2_ROW_SIZE,
    parameter int LOG2_COL_SIZE  = DEF_LOG2_COL_SIZE,
    parameter int BUFF_SIZE      = DEF_BUFF_SIZE,
    parameter int LOG2_BUFF_SIZE = DEF_LOG2_BUFF_SIZE,
    parameter int DATA_TYPE      = DEF_DATA_TYPE
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_TYPE-1:0]                 in_data,
    output logic                                 out_valid,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0]    out_bit_map,
    output logic [BUFF_SIZE-1:0][DATA_TYPE-1:0]  out_nonzero_ele,
    output logic [LOG2_BUFF_SIZE:0]              out_nnz,
    output logic                                 out_ovf,
    input  logic                                 tile_consumed
);

    localparam logic [LOG2_ROW_SIZE-1:0] ROW_LAST = LOG2_ROW_SIZE'(ROW_SIZE - 1);
    localparam logic [LOG2_COL_SIZE-1:0] COL_LAST = LOG2_COL_SIZE'(COL_SIZE - 1);

    logic [LOG2_ROW_SIZE-1:0]             row;
    logic [LOG2_COL_SIZE-1:0]             col;
    logic                                 accept;
    logic                                 last_elem;
    logic [ROW_SIZE-1:0][COL_SIZE-1:0]    sel_map;
    logic [BUFF_SIZE-1:0][DATA_TYPE-1:0]  sel_ele;
    logic [LOG2_BUFF_SIZE:0]              sel_nnz;
    logic                                 sel_ovf;

    assign accept    = in_valid && in_ready;
    assign last_elem = (row == ROW_LAST) && (col == COL_LAST);

    // row-major scan position of the next accepted element
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

`ifdef BITMAP_COMP_PINGPONG_EN
    state_t                               state_q [2];
    state_t                               state_d [2];
    bank_sel_t                            fill_sel, fill_sel_d;
    bank_sel_t                            pres_sel, pres_sel_d;
    logic [1:0]                           bank_clr;
    logic [ROW_SIZE-1:0][COL_SIZE-1:0]    bank_map [2];
    logic [BUFF_SIZE-1:0][DATA_TYPE-1:0]  bank_ele [2];
    logic [LOG2_BUFF_SIZE:0]              bank_nnz [2];
    logic [1:0]                           bank_ovf;

    // per-bank fill/full state plus which bank is being filled and which is presented
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q[0] <= FILL;
            state_q[1] <= FILL;
            fill_sel   <= 1'b0;
            pres_sel   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_sel <= fill_sel_d;
            pres_sel <= pres_sel_d;
        end
    end

    // completion and consumption hit different banks, so both may act on one edge without a gap
    always_comb begin
        state_d    = state_q;
        fill_sel_d = fill_sel;
        pres_sel_d = pres_sel;
        bank_clr   = 2'b00;
        if (accept && last_elem) begin
            state_d[fill_sel] = FULL;
            fill_sel_d        = ~fill_sel;
        end
        if (tile_consumed && (state_q[pres_sel] == FULL)) begin
            state_d[pres_sel]  = FILL;
            bank_clr[pres_sel] = 1'b1;
            pres_sel_d         = ~pres_sel;
        end
    end

    assign in_ready  = (state_q[fill_sel] == FILL);
    assign out_valid = (state_q[pres_sel] == FULL);

    for (genvar g = 0; g < 2; g++) begin : g_bank
        bitmap_bank #(
            .ROW_SIZE(ROW_SIZE), .COL_SIZE(COL_SIZE),
            .LOG2_ROW_SIZE(LOG2_ROW_SIZE), .LOG2_COL_SIZE(LOG2_COL_SIZE),
            .BUFF_SIZE(BUFF_SIZE), .LOG2_BUFF_SIZE(LOG2_BUFF_SIZE), .DATA_TYPE(DATA_TYPE)
        ) u_bank (
            .clk(clk), .rst(rst),
            .wr_en(accept && (fill_sel == 1'(g))), .clr(bank_clr[g]),
            .row(row), .col(col), .data(in_data),
            .bit_map(bank_map[g]), .ele(bank_ele[g]), .nnz(bank_nnz[g]), .ovf(bank_ovf[g])
        );
    end

    assign sel_map = bank_map[pres_sel];
    assign sel_ele = bank_ele[pres_sel];
    assign sel_nnz = bank_nnz[pres_sel];
    assign sel_ovf = bank_ovf[pres_sel];
`else
    state_t state_q, state_d;
    logic   bank_clr;

    // single tile state: filling or holding a finished tile
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= FILL;
        else      state_q <= state_d;
    end

    // finish the tile on the last scan position, release it on the consume pulse
    always_comb begin
        state_d  = state_q;
        bank_clr = 1'b0;
        case (state_q)
            FILL: if (accept && last_elem) state_d = FULL;
            FULL: if (tile_consumed) begin
                state_d  = FILL;
                bank_clr = 1'b1;
            end
        endcase
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);

    bitmap_bank #(
        .ROW_SIZE(ROW_SIZE), .COL_SIZE(COL_SIZE),
        .LOG2_ROW_SIZE(LOG2_ROW_SIZE), .LOG2_COL_SIZE(LOG2_COL_SIZE),
        .BUFF_SIZE(BUFF_SIZE), .LOG2_BUFF_SIZE(LOG2_BUFF_SIZE), .DATA_TYPE(DATA_TYPE)
    ) u_bank (
        .clk(clk), .rst(rst),
        .wr_en(accept), .clr(bank_clr),
        .row(row), .col(col), .data(in_data),
        .bit_map(sel_map), .ele(sel_ele), .nnz(sel_nnz), .ovf(sel_ovf)
    );
`endif

    // partially filled tiles are never exposed; idle outputs read zero
    assign out_bit_map     = out_valid ? sel_map : '0;
    assign out_nonzero_ele = out_valid ? sel_ele : '0;
    assign out_nnz         = out_valid ? sel_nnz : '0;
    assign out_ovf         = out_valid ? sel_ovf : 1'b0;

endmodule

// File: tb/tb_bitmap_compressor.sv
// tb/tb_bitmap_compressor.sv - randomized bench for bitmap_compressor against a tile-queue reference model
module tb_bitmap_compressor;

`ifdef BITMAP_COMP_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int NT = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [31:0]          in_data;
    logic                 tile_consumed;

    logic                 in_ready_a, out_valid_a, out_ovf_a;
    logic [3:0][7:0]      out_bit_map_a;
    logic [31:0][31:0]    out_nonzero_ele_a;
    logic [5:0]           out_nnz_a;

    logic                 in_ready_b, out_valid_b, out_ovf_b;
    logic [3:0][7:0]      out_bit_map_b;
    logic [3:0][31:0]     out_nonzero_ele_b;
    logic [2:0]           out_nnz_b;

    int n_vec = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    logic [31:0] tile_buf [NT];
    logic [31:0] partial [$];
    logic [31:0] flat [$];
    bit          m_acc;

    always #5 clk = ~clk;

    bitmap_compressor dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_bit_map(out_bit_map_a), .out_nonzero_ele(out_nonzero_ele_a),
        .out_nnz(out_nnz_a), .out_ovf(out_ovf_a), .tile_consumed(tile_consumed)
    );

    bitmap_compressor #(.BUFF_SIZE(4), .LOG2_BUFF_SIZE(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_bit_map(out_bit_map_b), .out_nonzero_ele(out_nonzero_ele_b),
        .out_nnz(out_nnz_b), .out_ovf(out_ovf_b), .tile_consumed(tile_consumed)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // reference model: completed tiles queued whole in fill order, the front one is presented
    function automatic bit model_ready();
        return (flat.size() / NT) < NB;
    endfunction

    function automatic bit exp_valid();
        return flat.size() >= NT;
    endfunction

    function automatic int exp_nz();
        int n = 0;
        if (!exp_valid()) return 0;
        for (int i = 0; i < NT; i++) if (flat[i] != 0) n++;
        return n;
    endfunction

    function automatic logic [31:0] exp_map();
        logic [31:0] m = '0;
        if (!exp_valid()) return '0;
        for (int i = 0; i < NT; i++) m[i] = (flat[i] != 0);
        return m;
    endfunction

    function automatic logic [31:0] exp_ele(input int k, input int depth);
        int n = 0;
        if (!exp_valid() || k >= depth) return '0;
        for (int i = 0; i < NT; i++) begin
            if (flat[i] != 0) begin
                if (n == k) return flat[i];
                n++;
            end
        end
        return '0;
    endfunction

    function automatic int exp_nnz(input int depth);
        int n = exp_nz();
        return (n > depth) ? depth : n;
    endfunction

    // advance the model with what the DUT sees at each rising edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            partial.delete();
            flat.delete();
        end else begin
            m_acc = in_valid && model_ready();
            if (tile_consumed && exp_valid()) repeat (NT) void'(flat.pop_front());
            if (m_acc) begin
                partial.push_back(in_data);
                if (partial.size() == NT) begin
                    foreach (partial[i]) flat.push_back(partial[i]);
                    partial.delete();
                end
            end
        end
    end

    // compare both DUTs against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                chk("in_ready_a", in_ready_a, model_ready());
                chk("in_ready_b", in_ready_b, model_ready());
            end
            chk("out_valid_a", out_valid_a, exp_valid());
            chk("out_valid_b", out_valid_b, exp_valid());
            chk("bit_map_a", out_bit_map_a, exp_map());
            chk("bit_map_b", out_bit_map_b, exp_map());
            chk("nnz_a", out_nnz_a, exp_nnz(32));
            chk("nnz_b", out_nnz_b, exp_nnz(4));
            chk("ovf_a", out_ovf_a, exp_nz() > 32);
            chk("ovf_b", out_ovf_b, exp_nz() > 4);
            for (int k = 0; k < 32; k++)
                chk($sformatf("ele_a[%0d]", k), out_nonzero_ele_a[k], exp_ele(k, 32));
            for (int k = 0; k < 4; k++)
                chk($sformatf("ele_b[%0d]", k), out_nonzero_ele_b[k], exp_ele(k, 4));
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
    endtask

    task automatic consume();
        @(negedge clk); tile_consumed = 1'b1;
        @(negedge clk); tile_consumed = 1'b0;
    endtask

    task automatic rand_tile(input int nz_pct);
        for (int i = 0; i < NT; i++)
            tile_buf[i] = ($urandom_range(99) < nz_pct) ? ($urandom | 32'h1) : 32'h0;
    endtask

    // push the first n elements of tile_buf; returns at the negedge after the last accept
    task automatic send_tile(input int n, input int bubble_pct, input bit consume_last);
        int i = 0;
        int guard = 0;
        while (i < n) begin
            @(negedge clk);
            if ($urandom_range(99) < bubble_pct) begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_data  = tile_buf[i];
                if (consume_last && i == n - 1) tile_consumed = 1'b1;
            end
            if (in_valid && in_ready_a) i++;
            guard++;
            if (guard > 3000) begin
                n_vec++;
                n_bad++;
                $display("FAIL send_timeout: got %0d accepts expected %0d", i, n);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (consume_last) tile_consumed = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit done;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; tile_consumed = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_nnz", out_nnz_a, 0);
        @(posedge clk); #2 rst = 1'b1;

        // sparse row 0 tile
        for (int i = 0; i < NT; i++) tile_buf[i] = '0;
        tile_buf[2] = 32'h11; tile_buf[3] = 32'h22; tile_buf[5] = 32'h33; tile_buf[6] = 32'h44;
        send_tile(NT, 0, 1'b0);
        chk("t1_row0", out_bit_map_a[0], 8'b0110_1100);
        chk("t1_rows123", {out_bit_map_a[3], out_bit_map_a[2], out_bit_map_a[1]}, 24'h0);
        chk("t1_ele0", out_nonzero_ele_a[0], 32'h11);
        chk("t1_ele3", out_nonzero_ele_a[3], 32'h44);
        chk("t1_nnz", out_nnz_a, 4);
        chk("t1_ovf_b", out_ovf_b, 1'b0);
        consume();

        // all-zero tile straight after reset
        do_reset();
        for (int i = 0; i < NT; i++) tile_buf[i] = '0;
        send_tile(NT, 0, 1'b0);
        chk("t2_valid", out_valid_a, 1'b1);
        chk("t2_nnz", out_nnz_a, 0);
`ifndef BITMAP_COMP_PINGPONG_EN
        chk("t2_ready", in_ready_a, 1'b0);
`endif
        consume();

        // all 0xA5: overflows the 4-deep instance
        for (int i = 0; i < NT; i++) tile_buf[i] = 32'hA5;
        send_tile(NT, 30, 1'b0);
        chk("t3_map_b", out_bit_map_b, 32'hFFFF_FFFF);
        chk("t3_ele3_b", out_nonzero_ele_b[3], 32'hA5);
        chk("t3_nnz_b", out_nnz_b, 4);
        chk("t3_ovf_b", out_ovf_b, 1'b1);
        chk("t3_nnz_a", out_nnz_a, 32);
        // hold in_valid while the tile is held
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = $urandom;
        end
        @(negedge clk); in_valid = 1'b0;
        chk("t5_ovf_b", out_ovf_b, 1'b1);
        consume();
        chk("t3c_valid", out_valid_b, 1'b0);
        chk("t3c_ovf_b", out_ovf_b, 1'b0);
        chk("t3c_nnz_b", out_nnz_b, 0);
        consume();

        // reset after 10 accepts discards the partial tile
        rand_tile(100);
        send_tile(10, 20, 1'b0);
        do_reset();
        rand_tile(50);
        tile_buf[0] = 32'hDEAD_BEEF;
        send_tile(NT, 10, 1'b0);
        chk("t4_bit00", out_bit_map_a[0][0], 1'b1);
        chk("t4_ele0", out_nonzero_ele_a[0], 32'hDEAD_BEEF);
        consume();

        // random tiles with an independent random consumer
        done = 1'b0;
        fork
            begin
                for (int t = 0; t < 10; t++) begin
                    rand_tile((t % 3 == 0) ? (t * 11) % 101 : $urandom_range(100));
                    send_tile(NT, $urandom_range(40), 1'b0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    tile_consumed = ($urandom_range(99) < 25);
                end
                tile_consumed = 1'b0;
            end
        join

`ifdef BITMAP_COMP_PINGPONG_EN
        // back-to-back tiles with consumption on the edge the second completes
        do_reset();
        rand_tile(60);
        send_tile(NT, 0, 1'b0);
        rand_tile(60);
        tile_buf[0] = 32'hB0B0;
        send_tile(NT, 0, 1'b1);
        chk("t6_valid", out_valid_a, 1'b1);
        chk("t6_ready", in_ready_a, 1'b1);
        chk("t6_ele0", out_nonzero_ele_a[0], 32'hB0B0);
        consume();
`endif

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
